// File: rtl/instruction_decode_stage_pkg.sv
// rtl/instruction_decode_stage_pkg.sv - shared decode constants, enums and buffer entry type
package instruction_decode_stage_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef enum logic [3:0] {
        OC_LUI, OC_AUIPC, OC_JAL, OC_JALR, OC_BRANCH, OC_LOAD, OC_STORE,
        OC_OP_IMM, OC_OP, OC_OP_IMM_32, OC_OP_32, OC_MISC_MEM, OC_SYSTEM,
        OC_ILLEGAL
    } opclass_e;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_e;

    typedef enum logic [1:0] {BUF_EMPTY, BUF_ONE, BUF_TWO} buf_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        opclass_e        opclass;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } entry_t;

endpackage

// File: rtl/instruction_decode_stage_if.sv
// rtl/instruction_decode_stage_if.sv - fetch-to-decode beat channel plus redirect return path
interface instruction_decode_stage_if;
    import instruction_decode_stage_pkg::*;

    logic            valid;
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            ready;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;

    modport master (output valid, pc, instr, input ready, redirect, redirect_pc);
    modport slave  (input valid, pc, instr, output ready, redirect, redirect_pc);

endinterface

// File: rtl/instruction_decode_stage_imm_gen.sv
// rtl/instruction_decode_stage_imm_gen.sv - combinational RV64I opcode classifier and immediate generator
module instruction_decode_stage_imm_gen
    import instruction_decode_stage_pkg::*;
(
    input  logic [ILEN-1:0] i_instr,
    output logic [XLEN-1:0] o_imm,
    output opclass_e        o_opclass,
    output logic            o_illegal
);

    imm_fmt_e w_fmt;

    // classify the opcode; anything not ending in 2'b11 or not in the base set is illegal
    always_comb begin
        o_opclass = OC_ILLEGAL;
        o_illegal = 1'b1;
        w_fmt     = FMT_R;
        if (i_instr[1:0] == 2'b11) begin
            o_illegal = 1'b0;
            case (i_instr[6:0])
                OPC_LUI:       begin o_opclass = OC_LUI;       w_fmt = FMT_U; end
                OPC_AUIPC:     begin o_opclass = OC_AUIPC;     w_fmt = FMT_U; end
                OPC_JAL:       begin o_opclass = OC_JAL;       w_fmt = FMT_J; end
                OPC_JALR:      begin o_opclass = OC_JALR;      w_fmt = FMT_I; end
                OPC_BRANCH:    begin o_opclass = OC_BRANCH;    w_fmt = FMT_B; end
                OPC_LOAD:      begin o_opclass = OC_LOAD;      w_fmt = FMT_I; end
                OPC_STORE:     begin o_opclass = OC_STORE;     w_fmt = FMT_S; end
                OPC_OP_IMM:    begin o_opclass = OC_OP_IMM;    w_fmt = FMT_I; end
                OPC_OP:        begin o_opclass = OC_OP;        w_fmt = FMT_R; end
                OPC_OP_IMM_32: begin o_opclass = OC_OP_IMM_32; w_fmt = FMT_I; end
                OPC_OP_32:     begin o_opclass = OC_OP_32;     w_fmt = FMT_R; end
                OPC_MISC_MEM:  begin o_opclass = OC_MISC_MEM;  w_fmt = FMT_I; end
                OPC_SYSTEM:    begin o_opclass = OC_SYSTEM;    w_fmt = FMT_I; end
                default: begin
                    o_opclass = OC_ILLEGAL;
                    o_illegal = 1'b1;
                end
            endcase
        end
    end

    // assemble the sign-extended immediate for the selected format (R-type and illegal give 0)
    always_comb begin
        o_imm = '0;
        case (w_fmt)
            FMT_I: o_imm = {{52{i_instr[31]}}, i_instr[31:20]};
            FMT_S: o_imm = {{52{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            FMT_B: o_imm = {{51{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                            i_instr[11:8], 1'b0};
            FMT_U: o_imm = {{32{i_instr[31]}}, i_instr[31:12], 12'b0};
            FMT_J: o_imm = {{43{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                            i_instr[30:21], 1'b0};
            default: o_imm = '0;
        endcase
    end

endmodule

// File: rtl/instruction_decode_stage.sv
// rtl/instruction_decode_stage.sv - decode stage with 2-entry skid buffer and JAL redirect
module instruction_decode_stage
    import instruction_decode_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    instruction_decode_stage_if.slave  fetch,
    input  logic                       i_flush,
    output logic                       o_id_valid,
    input  logic                       i_id_ready,
    output logic [XLEN-1:0]            o_id_pc,
    output logic [ILEN-1:0]            o_id_instr,
    output logic [3:0]                 o_id_opclass,
    output logic [4:0]                 o_id_rd,
    output logic [4:0]                 o_id_rs1,
    output logic [4:0]                 o_id_rs2,
    output logic [2:0]                 o_id_funct3,
    output logic [6:0]                 o_id_funct7,
    output logic [XLEN-1:0]            o_id_imm,
    output logic                       o_id_illegal
);

    buf_state_e      r_state, w_state_nxt;
    entry_t          r_ent0, r_ent1;
    logic            r_ready, r_drop, r_redirect;
    logic [XLEN-1:0] r_redirect_pc;

    logic [XLEN-1:0] w_imm;
    opclass_e        w_opclass;
    logic            w_illegal;
    entry_t          w_new;
    logic            w_accept, w_keep, w_transfer, w_jal;

    instruction_decode_stage_imm_gen u_imm_gen (
        .i_instr   (fetch.instr),
        .o_imm     (w_imm),
        .o_opclass (w_opclass),
        .o_illegal (w_illegal)
    );

    assign w_new      = '{pc: fetch.pc, instr: fetch.instr, opclass: w_opclass,
                          imm: w_imm, illegal: w_illegal};
    // flush kills both the offered beat and the head transfer
    assign w_accept   = fetch.valid & r_ready & ~i_flush;
    // while a redirect is outstanding only the jump target is written; wrong-path beats are consumed and dropped
    assign w_keep     = w_accept & (~r_drop | (fetch.pc == r_redirect_pc));
    assign w_transfer = (r_state != BUF_EMPTY) & i_id_ready & ~i_flush;
    // a JAL that lands as the jump target is on the correct path, so it redirects too
    assign w_jal      = w_keep & (w_opclass == OC_JAL);

    // buffer occupancy next-state
    always_comb begin
        w_state_nxt = r_state;
        if (i_flush) begin
            w_state_nxt = BUF_EMPTY;
        end else begin
            case (r_state)
                BUF_EMPTY: if (w_keep) w_state_nxt = BUF_ONE;
                BUF_ONE: begin
                    if (w_keep && !w_transfer)      w_state_nxt = BUF_TWO;
                    else if (!w_keep && w_transfer) w_state_nxt = BUF_EMPTY;
                end
                BUF_TWO: if (w_transfer) w_state_nxt = BUF_ONE;
                default: w_state_nxt = BUF_EMPTY;
            endcase
        end
    end

    // state, entry storage, drop tracking and redirect pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= BUF_EMPTY;
            r_ready       <= 1'b1;
            r_ent0        <= '0;
            r_ent1        <= '0;
            r_drop        <= 1'b0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt != BUF_TWO);
            case (r_state)
                BUF_EMPTY: if (w_keep) r_ent0 <= w_new;
                BUF_ONE: begin
                    if (w_keep && w_transfer) r_ent0 <= w_new;
                    else if (w_keep)          r_ent1 <= w_new;
                end
                BUF_TWO: if (w_transfer) r_ent0 <= r_ent1;
                default: ;
            endcase
            r_redirect <= w_jal;
            if (w_jal) r_redirect_pc <= fetch.pc + w_imm;
            if (i_flush)     r_drop <= 1'b0;
            else if (w_jal)  r_drop <= 1'b1;
            else if (w_keep) r_drop <= 1'b0;
        end
    end

    assign fetch.ready       = r_ready;
    assign fetch.redirect    = r_redirect;
    assign fetch.redirect_pc = r_redirect_pc;

    assign o_id_valid   = (r_state != BUF_EMPTY);
    assign o_id_pc      = r_ent0.pc;
    assign o_id_instr   = r_ent0.instr;
    assign o_id_opclass = r_ent0.opclass;
    assign o_id_rd      = r_ent0.instr[11:7];
    assign o_id_rs1     = r_ent0.instr[19:15];
    assign o_id_rs2     = r_ent0.instr[24:20];
    assign o_id_funct3  = r_ent0.instr[14:12];
    assign o_id_funct7  = r_ent0.instr[31:25];
    assign o_id_imm     = r_ent0.imm;
    assign o_id_illegal = r_ent0.illegal;

endmodule
